reg_file_mp: RTL and testbench

Parametrised multi-port integer register file for the pipelined RV32I core. It supersedes the single-write, dual-read file. Adds configurable read/write port counts, same-cycle write-to-read bypass and a per-register busy scoreboard. Sits in decode: read ports feed operand fetch, write ports are driven from writeback, and the set port is driven from issue.

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 55 +++++
 rtl/reg_file_mp.sv | 101 ++++++++++
 tb/tb_reg_file_mp.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the integer register file.
package rf_pkg;

  parameter int unsigned XLEN     = 32;
  parameter int unsigned REG_ZERO = 0;
  parameter int unsigned REG_SP   = 2;
  parameter logic [31:0] SP_RESET = 32'h0000_1000;

  typedef logic [4:0]      reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: issue sets, clearing writes from writeback clear, set wins.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned NWR  = 1,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              set_en_i,
  input  logic [AW-1:0]     set_addr_i,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR-1:0]    wr_clr_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  output logic [NREG-1:0]   busy_vec_o
);

  // Bit 0 is the hardwired-zero register and never goes busy.
  localparam logic [NREG-1:0] LiveMask = {{(NREG-1){1'b1}}, 1'b0};

  logic [NREG-1:0] set_dec;
  logic [NREG-1:0] clr_dec;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] busy_q;

  // Decode the set request and all clearing writes into one-hot register vectors.
  always_comb begin
    set_dec = '0;
    clr_dec = '0;
    if (set_en_i) begin
      set_dec[set_addr_i] = 1'b1;
    end
    for (int unsigned w = 0; w < NWR; w++) begin
      if (wr_en_i[w] && wr_clr_i[w]) begin
        clr_dec[wr_addr_i[w*AW +: AW]] = 1'b1;
      end
    end
  end

  // A same-cycle set models a newer writer, so it overrides any clear.
  assign busy_d = (set_dec | (busy_q & ~clr_dec)) & LiveMask;

  // Busy-bit state.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with optional write-to-read bypass and busy scoreboard.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned     XLEN     = rf_pkg::XLEN,
  parameter int unsigned     NREG     = 32,
  parameter int unsigned     NRD      = 2,
  parameter int unsigned     NWR      = 1,
  parameter int unsigned     BYPASS   = 1,
  parameter int unsigned     SP_IDX   = REG_SP,
  parameter logic [XLEN-1:0] SP_RESET = XLEN'(rf_pkg::SP_RESET),
  localparam int unsigned    AW       = $clog2(NREG)
) (
  input  logic                clk_i,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic [NWR-1:0]      wr_clr_i,
  input  logic                set_en_i,
  input  logic [AW-1:0]       set_addr_i,
  output logic [NREG-1:0]     busy_vec_o
);

  logic [XLEN-1:0] regs_q  [NREG];
  logic [AW-1:0]   wr_addr [NWR];
  logic [XLEN-1:0] wr_data [NWR];
  logic [NREG-1:0] busy_vec;

  for (genvar w = 0; w < NWR; w++) begin : g_wr_unpack
    assign wr_addr[w] = wr_addr_i[w*AW +: AW];
    assign wr_data[w] = wr_data_i[w*XLEN +: XLEN];
  end

  // Storage: later write ports are applied last so the highest index wins a conflict.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[AW'(r)] <= (r == SP_IDX) ? SP_RESET : '0;
      end
    end else begin
      for (int unsigned w = 0; w < NWR; w++) begin
        if (wr_en_i[w] && (wr_addr[w] != '0)) begin
          regs_q[wr_addr[w]] <= wr_data[w];
        end
      end
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR),
    .AW   (AW)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .reset_n    (reset_n),
    .set_en_i   (set_en_i),
    .set_addr_i (set_addr_i),
    .wr_en_i    (wr_en_i),
    .wr_clr_i   (wr_clr_i),
    .wr_addr_i  (wr_addr_i),
    .busy_vec_o (busy_vec)
  );

  assign busy_vec_o = busy_vec;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_val;
    logic            rd_bsy;

    assign rd_addr = rd_addr_i[k*AW +: AW];

    // Read mux: stored value, overridden by same-cycle write data when bypass is enabled.
    always_comb begin
      rd_val = regs_q[rd_addr];
      rd_bsy = busy_vec[rd_addr];
      if (BYPASS != 0) begin
        for (int unsigned w = 0; w < NWR; w++) begin
          if (wr_en_i[w] && (wr_addr[w] == rd_addr)) begin
            rd_val = wr_data[w];
            if (wr_clr_i[w]) begin
              rd_bsy = 1'b0;
            end
          end
        end
      end
      if (rd_addr == '0) begin
        rd_val = '0;
        rd_bsy = 1'b0;
      end
    end

    assign rd_data_o[k*XLEN +: XLEN] = rd_val;
    assign rd_busy_o[k]              = rd_bsy;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: bypass and non-bypass instances share stimulus against one model.
module tb_reg_file_mp;

  logic        clk;
  logic        reset_n;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  wr_clr;
  logic        set_en;
  logic [4:0]  set_addr;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [31:0] busy_vec_b, busy_vec_n;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  reg_file_mp #(.NRD(2), .NWR(2), .BYPASS(1)) u_byp (
    .clk_i      (clk),
    .reset_n    (reset_n),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data_b),
    .rd_busy_o  (rd_busy_b),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_clr_i   (wr_clr),
    .set_en_i   (set_en),
    .set_addr_i (set_addr),
    .busy_vec_o (busy_vec_b)
  );

  reg_file_mp #(.NRD(2), .NWR(2), .BYPASS(0)) u_nob (
    .clk_i      (clk),
    .reset_n    (reset_n),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data_n),
    .rd_busy_o  (rd_busy_n),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_clr_i   (wr_clr),
    .set_en_i   (set_en),
    .set_addr_i (set_addr),
    .busy_vec_o (busy_vec_n)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int waddr(input int w);
    return int'(wr_addr[w*5 +: 5]);
  endfunction

  // Expected read value: register contents, or the highest enabled same-address write if bypassing.
  function automatic logic [31:0] exp_rd(input bit byp, input int a);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = m_regs[a];
    if (byp) begin
      for (int w = 0; w < 2; w++) begin
        if (wr_en[w] && waddr(w) == a) v = wr_data[w*32 +: 32];
      end
    end
    return v;
  endfunction

  function automatic logic exp_busy(input bit byp, input int a);
    logic b;
    if (a == 0) return 1'b0;
    b = m_busy[a];
    if (byp) begin
      for (int w = 0; w < 2; w++) begin
        if (wr_en[w] && wr_clr[w] && waddr(w) == a) b = 1'b0;
      end
    end
    return b;
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  // Reference model state, advanced on each clock edge.
  always @(posedge clk or negedge reset_n) begin : model
    bit s, c;
    if (!reset_n) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = (r == 2) ? 32'h0000_1000 : 32'h0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        s = set_en && (int'(set_addr) == r);
        c = 1'b0;
        for (int w = 0; w < 2; w++) begin
          if (wr_en[w] && wr_clr[w] && waddr(w) == r) c = 1'b1;
        end
        if (s) m_busy[r] = 1'b1;
        else if (c) m_busy[r] = 1'b0;
      end
      for (int w = 0; w < 2; w++) begin
        if (wr_en[w] && waddr(w) != 0) m_regs[waddr(w)] = wr_data[w*32 +: 32];
      end
    end
  end

  // Compare both instances against the model mid-cycle.
  always @(negedge clk) begin
    int a;
    if (chk_en && reset_n) begin
      for (int k = 0; k < 2; k++) begin
        a = int'(rd_addr[k*5 +: 5]);
        check("byp_rd_data", rd_data_b[k*32 +: 32], exp_rd(1'b1, a));
        check("nob_rd_data", rd_data_n[k*32 +: 32], exp_rd(1'b0, a));
        check("byp_rd_busy", {31'h0, rd_busy_b[k]}, {31'h0, exp_busy(1'b1, a)});
        check("nob_rd_busy", {31'h0, rd_busy_n[k]}, {31'h0, exp_busy(1'b0, a)});
      end
      check("byp_busy_vec", busy_vec_b, exp_vec());
      check("nob_busy_vec", busy_vec_n, exp_vec());
    end
  end

  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_clr   = '0;
    set_en   = 1'b0;
    set_addr = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    rd_addr = {5'd0, 5'd2};
    idle();
    #12;
    check("reset_sp_byp", rd_data_b[31:0], 32'h0000_1000);
    check("reset_sp_nob", rd_data_n[31:0], 32'h0000_1000);
    check("reset_busy_vec", busy_vec_b, 32'h0);
    next_cycle();
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Reset contents on every address.
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      @(negedge clk);
      check("reset_read_byp", rd_data_b[31:0], (a == 2) ? 32'h0000_1000 : 32'h0);
      check("reset_read_nob", rd_data_n[31:0], (a == 2) ? 32'h0000_1000 : 32'h0);
      next_cycle();
    end

    // Same-cycle write/read of x5.
    rd_addr = {5'd0, 5'd5};
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd5};
    wr_data = {32'h0, 32'hDEAD_BEEF};
    @(negedge clk);
    check("bypass_same_cycle", rd_data_b[31:0], 32'hDEAD_BEEF);
    check("nobypass_old_value", rd_data_n[31:0], 32'h0);
    next_cycle();
    idle();
    @(negedge clk);
    check("byp_x5_stored", rd_data_b[31:0], 32'hDEAD_BEEF);
    check("nob_x5_stored", rd_data_n[31:0], 32'hDEAD_BEEF);
    next_cycle();

    // Writes and sets to x0 are dropped.
    rd_addr  = {5'd5, 5'd0};
    wr_en    = 2'b01;
    wr_addr  = {5'd0, 5'd0};
    wr_data  = {32'h0, 32'hFFFF_FFFF};
    set_en   = 1'b1;
    set_addr = 5'd0;
    @(negedge clk);
    check("x0_bypass_zero", rd_data_b[31:0], 32'h0);
    next_cycle();
    idle();
    @(negedge clk);
    check("x0_stored_zero", rd_data_n[31:0], 32'h0);
    check("x0_busy_vec", busy_vec_b, 32'h0);
    next_cycle();

    // Dual-port write conflict on x7: port 1 wins.
    rd_addr = {5'd0, 5'd7};
    wr_en   = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {32'h22, 32'h11};
    @(negedge clk);
    check("conflict_bypass", rd_data_b[31:0], 32'h22);
    next_cycle();
    idle();
    @(negedge clk);
    check("conflict_stored", rd_data_n[31:0], 32'h22);
    next_cycle();

    // Set beats same-cycle clear; clear-only write then masks rd_busy and clears.
    set_en   = 1'b1;
    set_addr = 5'd9;
    rd_addr  = {5'd0, 5'd9};
    next_cycle();
    idle();
    @(negedge clk);
    check("set_x9_busy", busy_vec_n, 32'h0000_0200);
    next_cycle();
    wr_en    = 2'b01;
    wr_addr  = {5'd0, 5'd9};
    wr_data  = {32'h0, 32'h99};
    wr_clr   = 2'b01;
    set_en   = 1'b1;
    set_addr = 5'd9;
    next_cycle();
    set_en = 1'b0;
    @(negedge clk);
    check("set_wins_busy", busy_vec_b, 32'h0000_0200);
    check("clear_mask_byp", {31'h0, rd_busy_b[0]}, 32'h0);
    check("clear_nomask_nob", {31'h0, rd_busy_n[0]}, 32'h1);
    next_cycle();
    idle();
    @(negedge clk);
    check("cleared_x9", busy_vec_n, 32'h0);
    next_cycle();

    // Asynchronous reset mid-cycle with x3 written and busy.
    wr_en    = 2'b01;
    wr_addr  = {5'd0, 5'd3};
    wr_data  = {32'h0, 32'h55};
    set_en   = 1'b1;
    set_addr = 5'd3;
    rd_addr  = {5'd2, 5'd3};
    next_cycle();
    idle();
    @(negedge clk);
    check("x3_before_reset", rd_data_n[31:0], 32'h55);
    check("x3_busy_before", busy_vec_n, 32'h0000_0008);
    next_cycle();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_x3_byp", rd_data_b[31:0], 32'h0);
    check("async_x3_nob", rd_data_n[31:0], 32'h0);
    check("async_busy_vec", busy_vec_b | busy_vec_n, 32'h0);
    check("async_sp", rd_data_n[63:32], 32'h0000_1000);
    next_cycle();
    reset_n = 1'b1;

    // Randomized traffic, with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      bit narrow;
      narrow   = ($urandom_range(0, 1) == 1);
      wr_en    = 2'($urandom);
      wr_clr   = 2'($urandom);
      wr_data  = {$urandom, $urandom};
      set_en   = ($urandom_range(0, 2) == 0);
      if (narrow) begin
        wr_addr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
        set_addr = 5'($urandom_range(0, 3));
        rd_addr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      end else begin
        wr_addr  = 10'($urandom);
        set_addr = 5'($urandom);
        rd_addr  = 10'($urandom);
      end
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
      end else begin
        next_cycle();
      end
    end

    idle();
    next_cycle();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
